arm_fetch: RTL

- Instruction fetch unit: the producer of the 32-bit instruction word that the ARM decode stage consumes.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small PC-tagged queue and presents them to decode with a valid/ready handshake.
- Handles branch redirects (decode's pc_we/pc_in) by flushing the queue and discarding stale in-flight responses.

---
 rtl/arm_fetch.sv | 131 +++++++++++++
 1 files changed

// File: rtl/arm_fetch.sv
// Instruction fetch unit: issues credit-limited word requests to instruction
// memory, queues PC-tagged responses for decode, and flushes on branch redirect.
module arm_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int unsigned      CNT_W     = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned      PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(QUEUE_DEPTH - 1);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    logic             active;
    logic [31:0]      fetch_pc;
    logic [31:0]      exp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    entry_t           queue [QUEUE_DEPTH];

    logic [31:0]      redirect_aligned;
    logic [CNT_W:0]   committed;
    logic             credit;
    logic             req_fire;
    logic             pop;
    logic             drop_resp;
    logic             push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;

    // outstanding covers every response memory still owes, stale ones included,
    // so the credit limit also bounds drop_cnt to the counter width.
    assign committed = {1'b0, outstanding} + {1'b0, count} - {{CNT_W{1'b0}}, pop};
    assign credit    = committed < {1'b0, DEPTH_CNT};

    assign imem_req_valid = active & credit & ~redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign drop_resp = imem_resp_valid & (redirect_valid | (drop_cnt != '0));
    assign push      = imem_resp_valid & ~drop_resp;

    assign inst    = queue[rd_ptr].data;
    assign inst_pc = queue[rd_ptr].pc;

    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active      <= 1'b0;
            fetch_pc    <= RESET_PC;
            exp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                exp_pc   <= redirect_aligned;
                drop_cnt <= outstanding - CNT_W'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    exp_pc <= exp_pc + 32'd4;
                end
                if (drop_resp) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: queue storage is reset so inst and inst_pc read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                queue[i] <= '0;
            end
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                queue[wr_ptr] <= '{data: imem_resp_data, pc: exp_pc};
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
        end
    end

    // Credits make a push into a full queue impossible.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == DEPTH_CNT)));

endmodule
